// File: rtl/sdft_line_sequencer_if.sv
// Control bus between the line sequencer (master) and the sliding-DFT core (slave).
interface sdft_line_sequencer_if #(
  parameter int DATA_W     = 8,
  parameter int FREQ_W     = 16,
  parameter int BIN_ADDR_W = 6
);
  logic                  sdft_ready;
  logic [FREQ_W-1:0]     sdft_bin_out;
  logic [DATA_W-1:0]     sdft_sample;
  logic                  sdft_start;
  logic                  sdft_read;
  logic [BIN_ADDR_W-1:0] sdft_bin_addr;

  modport master (
    input  sdft_ready, sdft_bin_out,
    output sdft_sample, sdft_start, sdft_read, sdft_bin_addr
  );

  modport slave (
    output sdft_ready, sdft_bin_out,
    input  sdft_sample, sdft_start, sdft_read, sdft_bin_addr
  );
endinterface

// File: rtl/sdft_line_sequencer.sv
// Feeds ADC samples into the sliding-DFT core and, every SAMPLES_PER_LINE samples,
// sweeps all bins into the waterfall line RAM as one display row.
module sdft_line_sequencer #(
  parameter int DATA_W           = 8,
  parameter int FREQ_BINS        = 64,
  parameter int FREQ_W           = 16,
  parameter int SAMPLES_PER_LINE = 32,
  parameter int ROWS             = 64,
  parameter int READ_LAT         = 2,
  localparam int BIN_ADDR_W      = $clog2(FREQ_BINS),
  localparam int ROW_W           = $clog2(ROWS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_valid,
  input  logic [DATA_W-1:0]      sample_in,
  sdft_line_sequencer_if.master  sdft,
  output logic                   line_wr_en,
  output logic [BIN_ADDR_W-1:0]  line_wr_addr,
  output logic [FREQ_W-1:0]      line_wr_data,
  output logic [ROW_W-1:0]       row_index,
  output logic                   line_done,
  output logic                   overrun
);
  localparam int CNT_W = $clog2(SAMPLES_PER_LINE + 1);
  localparam int DRN_W = $clog2(READ_LAT + 1);
  localparam logic [BIN_ADDR_W-1:0] LAST_BIN = BIN_ADDR_W'(FREQ_BINS - 1);

  typedef enum logic [2:0] {
    IDLE, START, WAIT_BUSY, WAIT_DONE, READ_ARM, SWEEP, DRAIN, READ_END
  } state_t;

  state_t                             state;
  logic                               pend_vld;
  logic [DATA_W-1:0]                  pend_data;
  logic [CNT_W-1:0]                   sample_cnt;
  logic                               line_due;
  logic [DRN_W-1:0]                   drain_cnt;
  logic [READ_LAT:0]                  vld_pipe;
  logic [READ_LAT:0][BIN_ADDR_W-1:0]  addr_pipe;
  logic                               consume;

  // Line reads win over a pending sample, so a sample is only taken when no line is due.
  assign consume = (state == IDLE) && sdft.sdft_ready && !line_due && pend_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_vld  <= 1'b0;
      pend_data <= '0;
      overrun   <= 1'b0;
    end else if (sample_valid && (!pend_vld || consume)) begin
      pend_vld  <= 1'b1;
      pend_data <= sample_in;
    end else begin
      if (consume)      pend_vld <= 1'b0;
      if (sample_valid) overrun  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      sdft.sdft_sample   <= '0;
      sdft.sdft_start    <= 1'b0;
      sdft.sdft_read     <= 1'b0;
      sdft.sdft_bin_addr <= '0;
      sample_cnt         <= '0;
      line_due           <= 1'b0;
      drain_cnt          <= '0;
      row_index          <= '0;
      line_done          <= 1'b0;
      vld_pipe           <= '0;
      addr_pipe          <= '0;
    end else begin
      sdft.sdft_start <= 1'b0;
      line_done       <= 1'b0;
      // Stage 0 holds the address being presented this cycle; stage READ_LAT meets its magnitude.
      vld_pipe  <= {vld_pipe[READ_LAT-1:0], 1'b0};
      addr_pipe <= {addr_pipe[READ_LAT-1:0], BIN_ADDR_W'(0)};
      case (state)
        IDLE: begin
          if (sdft.sdft_ready && line_due) begin
            state              <= READ_ARM;
            sdft.sdft_read     <= 1'b1;
            sdft.sdft_bin_addr <= '0;
          end else if (consume) begin
            state            <= START;
            sdft.sdft_start  <= 1'b1;
            sdft.sdft_sample <= pend_data;
            sample_cnt       <= sample_cnt + 1'b1;
          end
        end
        START:     state <= WAIT_BUSY;
        WAIT_BUSY: if (!sdft.sdft_ready) state <= WAIT_DONE;
        WAIT_DONE: begin
          if (sdft.sdft_ready) begin
            state <= IDLE;
            if (sample_cnt == CNT_W'(SAMPLES_PER_LINE)) begin
              line_due   <= 1'b1;
              sample_cnt <= '0;
            end
          end
        end
        READ_ARM: begin
          state        <= SWEEP;
          vld_pipe[0]  <= 1'b1;
          addr_pipe[0] <= '0;
        end
        SWEEP: begin
          if (sdft.sdft_bin_addr == LAST_BIN) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            sdft.sdft_bin_addr <= sdft.sdft_bin_addr + 1'b1;
            vld_pipe[0]        <= 1'b1;
            addr_pipe[0]       <= sdft.sdft_bin_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRN_W'(READ_LAT - 1)) begin
            state              <= READ_END;
            sdft.sdft_read     <= 1'b0;
            sdft.sdft_bin_addr <= '0;
            line_done          <= 1'b1;
            line_due           <= 1'b0;
            row_index          <= (row_index == ROW_W'(ROWS - 1)) ? '0 : row_index + 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        READ_END:  if (sdft.sdft_ready) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  assign line_wr_en   = vld_pipe[READ_LAT];
  assign line_wr_addr = addr_pipe[READ_LAT];
  assign line_wr_data = line_wr_en ? sdft.sdft_bin_out : '0;
endmodule

// File: tb/tb_sdft_line_sequencer.sv
// Scoreboard bench: a behavioural DFT core model plus expected start/write queues.
module tb_sdft_line_sequencer;
  localparam int DATA_W = 8, FREQ_BINS = 64, FREQ_W = 16, SPL = 32, ROWS = 64, READ_LAT = 2;
  localparam int BIN_ADDR_W = 6, ROW_W = 6;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  sample_valid = 1'b0;
  logic [DATA_W-1:0]     sample_in = '0;
  logic                  line_wr_en, line_done, overrun;
  logic [BIN_ADDR_W-1:0] line_wr_addr;
  logic [FREQ_W-1:0]     line_wr_data;
  logic [ROW_W-1:0]      row_index;

  sdft_line_sequencer_if #(.DATA_W(DATA_W), .FREQ_W(FREQ_W), .BIN_ADDR_W(BIN_ADDR_W)) sdft ();

  sdft_line_sequencer #(
    .DATA_W(DATA_W), .FREQ_BINS(FREQ_BINS), .FREQ_W(FREQ_W),
    .SAMPLES_PER_LINE(SPL), .ROWS(ROWS), .READ_LAT(READ_LAT)
  ) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
    .sdft(sdft), .line_wr_en(line_wr_en), .line_wr_addr(line_wr_addr),
    .line_wr_data(line_wr_data), .row_index(row_index), .line_done(line_done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Core model: busy after start/read, magnitude = addr*3 two cycles after the address.
  int              busy = 0;
  logic            hold_low = 1'b0;
  logic [FREQ_W-1:0] d1 = '0, d2 = '0;
  always @(posedge clk) begin
    if (sdft.sdft_start)      busy <= 4;
    else if (sdft.sdft_read)  busy <= 2;
    else if (busy > 0)        busy <= busy - 1;
    d1 <= 16'(sdft.sdft_bin_addr) * 16'd3;
    d2 <= d1;
  end
  assign sdft.sdft_ready   = (busy == 0) && !hold_low;
  assign sdft.sdft_bin_out = d2;

  int n_tests = 0, n_fail = 0;
  int n_start = 0, n_done = 0, line_cnt = 0, exp_row = 0, cyc = 0, last_wr = -100;
  logic [DATA_W-1:0]     start_q[$];
  logic [BIN_ADDR_W-1:0] wa_q[$];
  logic [FREQ_W-1:0]     wd_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (sdft.sdft_start) begin
          chk("start_rdy", sdft.sdft_ready, 1);
          chk("start_rd_excl", sdft.sdft_read, 0);
          chk("prio_line_first", wa_q.size(), 0);
          chk("start_expected", start_q.size() != 0, 1);
          if (start_q.size() != 0) begin
            chk("start_sample", sdft.sdft_sample, start_q.pop_front());
            n_start++;
            line_cnt++;
            if (line_cnt == SPL) begin
              line_cnt = 0;
              for (int i = 0; i < FREQ_BINS; i++) begin
                wa_q.push_back(BIN_ADDR_W'(i));
                wd_q.push_back(16'(i * 3));
              end
            end
          end
        end
        if (line_wr_en) begin
          chk("wr_expected", wa_q.size() != 0, 1);
          if (wa_q.size() != 0) begin
            chk("wr_addr", line_wr_addr, wa_q.pop_front());
            chk("wr_data", line_wr_data, wd_q.pop_front());
          end
          last_wr = cyc;
        end
        if (line_done) begin
          chk("done_lat", cyc - last_wr, 1);
          chk("done_all_wr", wa_q.size(), 0);
          exp_row = (exp_row + 1) % ROWS;
          chk("row_idx", row_index, exp_row);
          n_done++;
        end
      end
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] v, input bit keep);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in    = v;
    if (keep) start_q.push_back(v);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (start_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) chk("start_timeout", start_q.size(), 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((start_q.size() != 0 || wa_q.size() != 0) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) chk("idle_timeout", start_q.size() + wa_q.size(), 0);
    repeat (8) @(negedge clk);
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      send(8'($urandom_range(0, 255)), 1'b1);
      wait_idle();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    chk("rst_start", sdft.sdft_start, 0);
    chk("rst_read", sdft.sdft_read, 0);
    chk("rst_addr", sdft.sdft_bin_addr, 0);
    chk("rst_sample", sdft.sdft_sample, 0);
    chk("rst_wr_en", line_wr_en, 0);
    chk("rst_wr_data", line_wr_data, 0);
    chk("rst_row", row_index, 0);
    chk("rst_done", line_done, 0);
    chk("rst_ovr", overrun, 0);
    reset = 1'b0;

    // single sample
    send(8'h5A, 1'b1);
    wait_idle();
    repeat (10) @(negedge clk);
    chk("single_start_cnt", n_start, 1);
    chk("single_no_ovr", overrun, 0);

    // overrun while the core holds ready low
    hold_low = 1'b1;
    send(8'hA1, 1'b1);
    send(8'hB2, 1'b0);
    @(negedge clk);
    chk("ovr_set", overrun, 1);
    chk("ovr_no_start", n_start, 1);
    hold_low = 1'b0;
    wait_idle();
    chk("ovr_start_cnt", n_start, 2);
    chk("ovr_sticky", overrun, 1);

    // first full line
    feed(SPL - 2);
    chk("line1_row", row_index, 1);
    chk("line1_done", n_done, 1);

    // line due and a sample pending when ready returns
    feed(SPL - 1);
    send(8'h3C, 1'b1);
    wait_start();
    send(8'hC3, 1'b1);
    wait_idle();
    chk("prio_row", row_index, 2);
    chk("prio_done", n_done, 2);
    chk("prio_starts", n_start, 2 + 2 * SPL - 1);

    // reset in the middle of a sweep
    feed(SPL - 2);
    send(8'h77, 1'b1);
    wait_start();
    n = 0;
    while (!(sdft.sdft_read && sdft.sdft_bin_addr == 6'd20) && n < 500) begin
      @(negedge clk); n++;
    end
    chk("reach_bin20", sdft.sdft_bin_addr, 20);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_read", sdft.sdft_read, 0);
    chk("mid_rst_wr_en", line_wr_en, 0);
    chk("mid_rst_row", row_index, 0);
    chk("mid_rst_start", sdft.sdft_start, 0);
    chk("mid_rst_ovr", overrun, 0);
    start_q.delete(); wa_q.delete(); wd_q.delete();
    line_cnt = 0; exp_row = 0; n_done = 0;
    @(negedge clk);
    reset = 1'b0;

    feed(SPL);
    chk("after_rst_row", row_index, 1);

    // run to 64 lines since reset: row wraps back to 0
    feed(SPL * (ROWS - 1));
    chk("wrap_done_cnt", n_done, ROWS);
    chk("wrap_row", row_index, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sdft_line_sequencer.md
Name: sdft_line_sequencer

Overview:
- Initiator/master for the sliding-DFT core's control interface.
- Accepts the ADC sample stream and issues one `start` per sample while the core is ready.
- Every SAMPLES_PER_LINE samples, drives a `read` sweep over all frequency bins.
- Writes the returned magnitudes into the waterfall line RAM as one display row, then advances the row index.

Parameters:
- DATA_W, 8, sample width
- FREQ_BINS, 64, number of bins swept per line
- FREQ_W, 16, magnitude width
- SAMPLES_PER_LINE, 32, samples pushed into the DFT between line reads
- ROWS, 64, waterfall rows; row index wraps at ROWS
- READ_LAT, 2, cycles from a bin address being presented during the sweep to its magnitude on `bin_out`
- Derived: BIN_ADDR_W = clog2(FREQ_BINS), ROW_W = clog2(ROWS)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sample_valid  in  1  one-cycle strobe, new ADC sample
- sample_in  in  DATA_W  ADC sample
- sdft_ready  in  1  DFT core idle (high only when the core accepts start/read)
- sdft_bin_out  in  FREQ_W  magnitude from the DFT core
- sdft_sample  out  DATA_W  sample presented to the core
- sdft_start  out  1  one-cycle start request
- sdft_read  out  1  read request, held for the whole sweep
- sdft_bin_addr  out  BIN_ADDR_W  bin being read
- line_wr_en  out  1  line RAM write strobe
- line_wr_addr  out  BIN_ADDR_W  column (bin index)
- line_wr_data  out  FREQ_W  magnitude
- row_index  out  ROW_W  row currently being written
- line_done  out  1  one-cycle pulse after the last bin of a row is written
- overrun  out  1  sticky: a sample was dropped

Behaviour:
- Reset (asynchronous) state:
  - All outputs are 0; FSM is in IDLE; pending buffer is empty.
  - sample counter, row_index and overrun are cleared.
  - Reset mid-sweep or mid-start drops `sdft_start` and `sdft_read` immediately.
  - The core has no reset, so after reset the FSM issues nothing until `sdft_ready` is high.
- Pending buffer (1 entry):
  - `sample_valid` with the buffer empty stores `sample_in` and sets pending.
  - `sample_valid` with the buffer full drops the new sample and sets `overrun` (sticky until reset).
  - A simultaneous consume and `sample_valid` is accepted; no overrun.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, READ_ARM, SWEEP, DRAIN, READ_END.
- IDLE:
  - If `sdft_ready` and line_due: go to READ_ARM. Line reads have priority over a pending sample.
  - Else if `sdft_ready` and pending: go to START.
- START:
  - `sdft_sample` = buffered sample; `sdft_start` = 1 for exactly one cycle.
  - Consumes the buffer; increments the sample counter.
  - Then go to WAIT_BUSY.
- WAIT_BUSY: wait for `sdft_ready` low, then go to WAIT_DONE.
- WAIT_DONE:
  - Wait for `sdft_ready` high.
  - If the sample counter == SAMPLES_PER_LINE: set line_due and clear the counter.
  - Return to IDLE.
- READ_ARM: `sdft_read` = 1, `sdft_bin_addr` = 0 for one cycle while the core enters read mode.
- SWEEP:
  - `sdft_bin_addr` steps 0..FREQ_BINS-1, one per cycle; `sdft_read` held high.
  - A READ_LAT-deep valid/address delay line tracks each presented address.
- DRAIN:
  - READ_LAT cycles, address held at FREQ_BINS-1, `sdft_read` high.
- Line RAM writes:
  - When a delayed valid emerges: `line_wr_en` = 1, `line_wr_addr` = delayed address, `line_wr_data` = `sdft_bin_out` (passed through, same cycle).
  - Exactly FREQ_BINS writes per line, addresses strictly ascending 0..FREQ_BINS-1.
- READ_END:
  - `sdft_read` = 0; `line_done` pulses for one cycle.
  - `row_index` increments, wrapping ROWS-1 → 0; line_due clears.
  - Wait for `sdft_ready` high, then return to IDLE.
- Protocol invariants:
  - `sdft_start` and `sdft_read` are never both high.
  - `sdft_start` is never asserted while `sdft_ready` is low.
- Samples arriving during a sweep are buffered or dropped under the rules above. Width rules: none (no arithmetic on the data path).

Test Plan:
- Single-sample push:
  - Stimulus: after reset, `sdft_ready` = 1, `sample_valid` with 0x5A.
  - Response: exactly one `sdft_start` pulse with `sdft_sample` = 0x5A; no further start until the responder model has dropped and re-raised ready.
- Line sweep:
  - Stimulus: 32 samples, responder model returns `bin_out` = addr*3 with a 2-cycle delay.
  - Response: 64 writes; `line_wr_addr` 0..63 with `line_wr_data` = addr*3; `line_done` one cycle after the last write; `row_index` 0 → 1.
- Overrun:
  - Stimulus: hold `sdft_ready` low, send 2 samples.
  - Response: first is kept, second is dropped, `overrun` = 1; on ready, `sdft_sample` carries the first sample.
- Priority:
  - Stimulus: line due and a sample pending when ready rises.
  - Response: `sdft_read` asserts first; the sample's start is issued after the sweep ends.
- Reset mid-sweep:
  - Stimulus: assert reset at bin 20.
  - Response: `sdft_read`, `line_wr_en` and `row_index` go to 0 asynchronously; the next line restarts at bin 0 after 32 new samples.
- Row wrap:
  - Stimulus: run 64 lines.
  - Response: `row_index` goes 63 → 0; `line_done` count = 64.
